// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: MULTU/MULT via shift-add, DIVU/DIV via restoring
// division, one bit per cycle. Produces the {hi, lo} pair written into HI/LO.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;       // {hi part, lo part} working register
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 div_zero_q, div_zero_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 sgn_a, sgn_b;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_sub;
  logic [2*WIDTH-1:0]   mul_next, div_next;
  logic [WIDTH-1:0]     q_fix, r_fix;

  // Operand magnitudes and one datapath step for each operation
  always_comb begin
    sgn_a = op[0] & srcA[WIDTH-1];
    sgn_b = op[0] & srcB[WIDTH-1];
    // Negating MIN yields MIN, which read unsigned is exactly 2^(WIDTH-1)
    mag_a = sgn_a ? (~srcA + 1'b1) : srcA;
    mag_b = sgn_b ? (~srcB + 1'b1) : srcB;

    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opnd_q};
    // Top bit of rem_sub is the borrow: set means the divisor did not fit
    div_next = rem_sub[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    q_fix = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    r_fix = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        // The done cycle itself does not accept a new request
        if (start && !done_q) begin
          is_div_d   = op[1];
          sign_a_d   = sgn_a;
          sign_b_d   = sgn_b;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          if (op[1]) begin
            opnd_d = mag_b;
            if (srcB == '0) begin
              dz_d    = 1'b1;
              acc_d   = {srcA, {WIDTH{1'b1}}};
              state_d = StFix;
            end else begin
              dz_d    = 1'b0;
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              state_d = StCalc;
            end
          end else begin
            dz_d    = 1'b0;
            opnd_d  = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (!dz_q) begin
          if (is_div_q) begin
            acc_d = {r_fix, q_fix};
          end else if (sign_a_q ^ sign_b_q) begin
            acc_d = {(2*WIDTH){1'b0}} - acc_q;
          end
        end
        state_d = StDone;
      end
      StDone: begin
        hi_d       = acc_q[2*WIDTH-1:WIDTH];
        lo_d       = acc_q[WIDTH-1:0];
        done_d     = 1'b1;
        busy_d     = 1'b0;
        div_zero_d = dz_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dz_q       <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dz_q       <= dz_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;

  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpMult  = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;
  localparam logic [1:0] OpDiv   = 2'b11;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int k_edge = 0;
  int lat;
  int seen;
  logic busy_mid;

  mul_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divZero(divZero)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge CLK);
    #1;
    k_edge = cyc_cnt;
    start = 1'b0; srcA = $urandom; srcB = $urandom;
  endtask

  // Wait (bounded) for done; latency counted in edges after the accepting edge
  task automatic wait_done(output int l, output logic bm);
    bm = 1'b0;
    l = 0;
    while (!done && l < 100) begin
      @(posedge CLK);
      #1;
      l = cyc_cnt - k_edge;
      if (l == 1) bm = busy;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dz", 64'(divZero), 64'd0);
    @(negedge CLK); reset = 1'b1;

    // 1. MULTU
    start_op(OpMultu, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(lat, busy_mid);
    chk("multu_lat", 64'(lat), 64'd34);
    chk("multu_busy_mid", 64'(busy_mid), 64'd1);
    chk("multu_busy_done", 64'(busy), 64'd0);
    chk("multu_res", {hi, lo}, 64'h00000001_FFFFFFFE);
    @(posedge CLK); #1;
    chk("multu_done_pulse", 64'(done), 64'd0);
    chk("multu_hold", {hi, lo}, 64'h00000001_FFFFFFFE);

    // 2. MULT signed
    start_op(OpMult, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, busy_mid);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    start_op(OpMult, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, busy_mid);
    chk("mult_min", {hi, lo}, 64'h40000000_00000000);

    // 3. Divides
    start_op(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, busy_mid);
    chk("div_lat", 64'(lat), 64'd34);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    start_op(OpDivu, 32'd100, 32'd7);
    wait_done(lat, busy_mid);
    chk("divu", {hi, lo}, 64'h00000002_0000000E);
    start_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, busy_mid);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    chk("div_ovf_dz", 64'(divZero), 64'd0);

    // 4. Divide by zero, then clear on next accepted start
    start_op(OpDivu, 32'd10, 32'd0);
    wait_done(lat, busy_mid);
    chk("dz_lat", 64'(lat), 64'd2);
    chk("dz_flag", 64'(divZero), 64'd1);
    chk("dz_res", {hi, lo}, 64'h0000000A_FFFFFFFF);
    start_op(OpDivu, 32'd100, 32'd7);
    chk("dz_clear", 64'(divZero), 64'd0);
    wait_done(lat, busy_mid);
    chk("dz_next_res", {hi, lo}, 64'h00000002_0000000E);

    // 5. start during a MULT is ignored
    start_op(OpMult, 32'hFFFF_FFFD, 32'd5);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    start = 1'b1; op = OpMultu; srcA = 32'd3; srcB = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(lat, busy_mid);
    chk("ign_lat", 64'(lat), 64'd34);
    chk("ign_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done || busy) seen++;
    end
    chk("ign_single", 64'(seen), 64'd0);

    // 6. reset mid-DIV
    start_op(OpDiv, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(posedge CLK);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) seen++;
    end
    chk("rst_mid_nodone", 64'(seen), 64'd0);
    start_op(OpDivu, 32'd100, 32'd7);
    wait_done(lat, busy_mid);
    chk("rst_fresh_lat", 64'(lat), 64'd34);
    chk("rst_fresh_res", {hi, lo}, 64'h00000002_0000000E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
